// File: rtl/jtframe_dwnld_pack_pkg.sv
// Shared types for the download write packer: output FSM states and write-mask encodings.
package jtframe_dwnld_pack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Mask bit set = lane not written; even bytes land in the low lane.
  localparam logic [1:0] MASK_EVEN = 2'b10;
  localparam logic [1:0] MASK_ODD  = 2'b01;
  localparam logic [1:0] MASK_NONE = 2'b11;

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// Small register FIFO buffering packed download bytes ahead of the SDRAM write FSM.
module jtframe_dwnld_fifo
  import jtframe_dwnld_pack_pkg::*;
#(
  parameter int W     = 33,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // Pointers wrap naturally at log2(DEPTH) bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/jtframe_dwnld_pack.sv
// Maps ioctl download bytes to SDRAM bank/word address, queues them and issues one masked write per byte.
module jtframe_dwnld_pack
  import jtframe_dwnld_pack_pkg::*;
#(
  parameter int          AW        = 22,
  parameter int          DEPTH     = 4,
  parameter logic [25:0] BA1_START = 26'h100_0000,
  parameter logic [25:0] BA2_START = 26'h200_0000,
  parameter logic [25:0] BA3_START = 26'h300_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          downloading_i,
  input  logic [25:0]   ioctl_addr_i,
  input  logic [7:0]    ioctl_dout_i,
  input  logic          ioctl_wr_i,
  output logic [AW-1:0] prog_addr_o,
  output logic [15:0]   prog_data_o,
  output logic [1:0]    prog_mask_o,
  output logic [1:0]    prog_ba_o,
  output logic          prog_we_o,
  output logic          prog_rd_o,
  input  logic          prog_ack_i,
  input  logic          prog_rdy_i,
  output logic          dwnld_busy_o,
  output logic          overflow_o
);

  localparam int W  = 2 + AW + 8 + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [1:0]    in_ba;
  logic [25:0]   in_base, in_offset;
  logic [W-1:0]  in_entry, head;
  logic [CW-1:0] count;
  logic          full, empty, pop;
  logic          unused_offset;

  always_comb begin
    in_ba   = 2'd0;
    in_base = '0;
    if (ioctl_addr_i >= BA3_START) begin
      in_ba   = 2'd3;
      in_base = BA3_START;
    end else if (ioctl_addr_i >= BA2_START) begin
      in_ba   = 2'd2;
      in_base = BA2_START;
    end else if (ioctl_addr_i >= BA1_START) begin
      in_ba   = 2'd1;
      in_base = BA1_START;
    end
  end

  assign in_offset     = ioctl_addr_i - in_base;
  assign in_entry      = {in_ba, in_offset[AW:1], ioctl_dout_i, in_offset[0]};
  assign unused_offset = ^in_offset[25:AW+1];

  jtframe_dwnld_fifo #(.W(W), .DEPTH(DEPTH), .PW(PW), .CW(CW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (ioctl_wr_i),
    .pop_i   (pop),
    .din_i   (in_entry),
    .dout_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [15:0]   data_q;
  logic [1:0]    mask_q, ba_q;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic          dl_q;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: if (!empty) begin
        pop     = 1'b1;
        state_d = ST_REQ;
      end
      ST_REQ:  if (prog_ack_i) state_d = prog_rdy_i ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (prog_rdy_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A drop sets the flag even in the cycle a new download window opens.
  assign ovf_d  = (ovf_q & ~(downloading_i & ~dl_q)) | (ioctl_wr_i & full);
  assign busy_d = downloading_i | (count != '0) | (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= MASK_NONE;
      ba_q    <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      dl_q    <= downloading_i;
      if (pop) begin
        ba_q   <= head[W-1 -: 2];
        addr_q <= head[W-3 -: AW];
        data_q <= {head[8:1], head[8:1]};
        mask_q <= head[0] ? MASK_ODD : MASK_EVEN;
      end
    end
  end

  assign prog_we_o    = (state_q == ST_REQ);
  assign prog_rd_o    = 1'b0;
  assign prog_addr_o  = addr_q;
  assign prog_data_o  = data_q;
  assign prog_mask_o  = mask_q;
  assign prog_ba_o    = ba_q;
  assign dwnld_busy_o = busy_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_jtframe_dwnld_pack.sv
// Directed bench for jtframe_dwnld_pack: vector table for mapping/latency plus hand sequences for handshake corners.
module tb_jtframe_dwnld_pack;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        downloading = 1'b0, ioctl_wr = 1'b0, prog_ack = 1'b0, prog_rdy = 1'b0;
  logic [25:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask, prog_ba;
  logic        prog_we, prog_rd, dwnld_busy, overflow;
  int          checks = 0, errors = 0;

  jtframe_dwnld_pack #(
    .AW(22), .DEPTH(4),
    .BA1_START(26'h010_0000), .BA2_START(26'h020_0000), .BA3_START(26'h030_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .downloading_i (downloading),
    .ioctl_addr_i  (ioctl_addr),
    .ioctl_dout_i  (ioctl_dout),
    .ioctl_wr_i    (ioctl_wr),
    .prog_addr_o   (prog_addr),
    .prog_data_o   (prog_data),
    .prog_mask_o   (prog_mask),
    .prog_ba_o     (prog_ba),
    .prog_we_o     (prog_we),
    .prog_rd_o     (prog_rd),
    .prog_ack_i    (prog_ack),
    .prog_rdy_i    (prog_rdy),
    .dwnld_busy_o  (dwnld_busy),
    .overflow_o    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] a;
    logic [7:0]  d;
    logic [1:0]  ba;
    logic [21:0] addr;
    logic [1:0]  mask;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [25:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick;
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_we(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (prog_we) got = 1'b1;
      else tick;
    end
  endtask

  task automatic finish_xfer;
    prog_ack = 1'b1;
    tick;
    prog_ack = 1'b0;
    check("we_low_in_wait", {31'd0, prog_we}, 32'd0);
    prog_rdy = 1'b1;
    tick;
    prog_rdy = 1'b0;
  endtask

  initial begin
    bit got;
    int n;

    vecs[0] = '{26'h000_0010, 8'hA5, 2'd0, 22'h00_0008, 2'b10};
    vecs[1] = '{26'h00F_FFFF, 8'h3C, 2'd0, 22'h07_FFFF, 2'b01};
    vecs[2] = '{26'h010_0000, 8'h5A, 2'd1, 22'h00_0000, 2'b10};
    vecs[3] = '{26'h030_0003, 8'hC3, 2'd3, 22'h00_0001, 2'b01};
    vecs[4] = '{26'h02A_BCDE, 8'h11, 2'd2, 22'h05_5E6F, 2'b10};
    vecs[5] = '{26'h020_0000, 8'h96, 2'd2, 22'h00_0000, 2'b10};
    vecs[6] = '{26'h3FF_FFFF, 8'hE1, 2'd3, 22'h27_FFFF, 2'b01};

    repeat (2) @(posedge clk);
    #1;
    check("rst_we",   {31'd0, prog_we}, 32'd0);
    check("rst_rd",   {31'd0, prog_rd}, 32'd0);
    check("rst_mask", {30'd0, prog_mask}, 32'd3);
    check("rst_addr", {10'd0, prog_addr}, 32'd0);
    check("rst_data", {16'd0, prog_data}, 32'd0);
    check("rst_ba",   {30'd0, prog_ba}, 32'd0);
    check("rst_busy", {31'd0, dwnld_busy}, 32'd0);
    check("rst_ovf",  {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    downloading = 1'b1;
    for (int v = 0; v < 7; v++) begin
      strobe(vecs[v].a, vecs[v].d);
      check("lat_n1_we_low", {31'd0, prog_we}, 32'd0);
      tick;
      check("lat_n2_we_high", {31'd0, prog_we}, 32'd1);
      check("vec_ba",   {30'd0, prog_ba}, {30'd0, vecs[v].ba});
      check("vec_addr", {10'd0, prog_addr}, {10'd0, vecs[v].addr});
      check("vec_data", {16'd0, prog_data}, {16'd0, vecs[v].d, vecs[v].d});
      check("vec_mask", {30'd0, prog_mask}, {30'd0, vecs[v].mask});
      finish_xfer;
    end
    check("busy_in_window", {31'd0, dwnld_busy}, 32'd1);
    downloading = 1'b0;
    tick;
    check("busy_falls", {31'd0, dwnld_busy}, 32'd0);

    // Overflow: 6 back-to-back bytes with ack held low.
    downloading = 1'b1;
    for (int i = 0; i < 6; i++) strobe(26'h40 + 26'(i), 8'h10 + 8'(i));
    tick;
    check("ovf_set", {31'd0, overflow}, 32'd1);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      wait_we(got);
      if (!got) break;
      check("ovf_data", {16'd0, prog_data}, {16'd0, 8'h10 + 8'(n), 8'h10 + 8'(n)});
      n++;
      finish_xfer;
    end
    check("ovf_writes", n, 32'd5);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    downloading = 1'b0;
    tick;
    downloading = 1'b1;
    tick;
    tick;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Combined ack+rdy in the REQ cycle.
    strobe(26'h50, 8'h77);
    strobe(26'h51, 8'h88);
    wait_we(got);
    check("comb_first_req", {31'd0, got}, 32'd1);
    check("comb_first_data", {16'd0, prog_data}, 32'h7777);
    prog_ack = 1'b1;
    prog_rdy = 1'b1;
    tick;
    prog_ack = 1'b0;
    prog_rdy = 1'b0;
    check("comb_idle_gap", {31'd0, prog_we}, 32'd0);
    tick;
    check("comb_next_req", {31'd0, prog_we}, 32'd1);
    check("comb_next_data", {16'd0, prog_data}, 32'h8888);
    check("comb_next_mask", {30'd0, prog_mask}, 32'd1);
    finish_xfer;

    // Drain after the window closes with entries still queued.
    for (int i = 0; i < 4; i++) strobe(26'h60 + 26'(i), 8'hD0 + 8'(i));
    downloading = 1'b0;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      wait_we(got);
      if (!got) break;
      check("drain_busy", {31'd0, dwnld_busy}, 32'd1);
      check("drain_data", {16'd0, prog_data}, {16'd0, 8'hD0 + 8'(k), 8'hD0 + 8'(k)});
      n++;
      finish_xfer;
    end
    check("drain_writes", n, 32'd4);
    check("drain_busy_after_rdy", {31'd0, dwnld_busy}, 32'd1);
    tick;
    check("drain_busy_low", {31'd0, dwnld_busy}, 32'd0);
    wait_we(got);
    check("drain_no_extra", {31'd0, got}, 32'd0);

    // Asynchronous reset while a request is outstanding.
    downloading = 1'b1;
    strobe(26'h70, 8'h01);
    strobe(26'h72, 8'h02);
    wait_we(got);
    check("rstmid_req", {31'd0, got}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_we",   {31'd0, prog_we}, 32'd0);
    check("rstmid_mask", {30'd0, prog_mask}, 32'd3);
    check("rstmid_busy", {31'd0, dwnld_busy}, 32'd0);
    @(negedge clk);
    downloading = 1'b0;
    rst_n = 1'b1;
    wait_we(got);
    check("rstmid_fifo_empty", {31'd0, got}, 32'd0);
    check("rstmid_idle_busy", {31'd0, dwnld_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
